// File: rtl/argmax_pkg.sv
// Shared state type and sign-magnitude ordering helpers for stream_argmax.
// Callers pass zero-extended codes plus the real width; SmMaxW bounds DATA_W.
package argmax_pkg;

  localparam int unsigned SmMaxW = 64;

  typedef enum logic {
    ACC,
    HOLD
  } state_e;

  // Saturation code: sign bit set, magnitude zero ("negative zero").
  function automatic logic [SmMaxW-1:0] sm_sat(input int unsigned width);
    return SmMaxW'(1) << (width - 1);
  endfunction

  // Strict ordering: SAT > positives (by magnitude) > negatives (smaller magnitude higher).
  function automatic logic sm_gt(input logic [SmMaxW-1:0] a,
                                 input logic [SmMaxW-1:0] b,
                                 input int unsigned       width);
    logic [SmMaxW-1:0] sat;
    logic [SmMaxW-1:0] mask;
    logic [SmMaxW-1:0] a_mag;
    logic [SmMaxW-1:0] b_mag;
    logic              a_neg;
    logic              b_neg;
    sat   = sm_sat(width);
    mask  = sat - SmMaxW'(1);
    a_mag = a & mask;
    b_mag = b & mask;
    a_neg = |(a & sat);
    b_neg = |(b & sat);
    if (b == sat) return 1'b0;
    if (a == sat) return 1'b1;
    if (a_neg != b_neg) return b_neg;
    if (!a_neg) return a_mag > b_mag;
    return a_mag < b_mag;
  endfunction

endpackage

// File: rtl/sm_compare.sv
// Combinational strict-greater comparator for sign-magnitude scores.
module sm_compare
  import argmax_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              a_gt_b_o
);

  assign a_gt_b_o = sm_gt(SmMaxW'(a_i), SmMaxW'(b_i), DATA_W);

endmodule

// File: rtl/stream_argmax.sv
// Streaming arg-max over NUM_CH sign-magnitude beats; result held until consumed.
// Define ARGMAX_TOP2_EN to also track and report the runner-up.
module stream_argmax
  import argmax_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned NUM_CH = 10,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_index,
`ifdef ARGMAX_TOP2_EN
  output logic [DATA_W-1:0] out_max2,
  output logic [IDX_W-1:0]  out_index2,
`endif
  output logic              out_sat
);

  localparam logic [IDX_W-1:0]  LastBeat = IDX_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] SatCode  = DATA_W'(sm_sat(DATA_W));

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic                sat_q, sat_d;
  logic [DATA_W-1:0]   out_max_q, out_max_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic                out_sat_q, out_sat_d;

  logic                accept;
  logic                first_beat;
  logic                last_beat;
  logic                beat_is_sat;
  logic                beat_gt_best;
  logic [IDX_W-1:0]    beat_idx;

  assign in_ready    = (state_q == ACC);
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_valid & in_ready;
  assign first_beat  = (count_q == '0);
  assign last_beat   = (count_q == LastBeat);
  assign beat_is_sat = (in_data == SatCode);
  // Beat 0 maps to the highest class number.
  assign beat_idx    = LastBeat - count_q;

  sm_compare #(
    .DATA_W (DATA_W)
  ) u_cmp_best (
    .a_i      (in_data),
    .b_i      (best_q),
    .a_gt_b_o (beat_gt_best)
  );

`ifdef ARGMAX_TOP2_EN
  logic [DATA_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]  second_idx_q, second_idx_d;
  logic [DATA_W-1:0] out_max2_q, out_max2_d;
  logic [IDX_W-1:0]  out_index2_q, out_index2_d;
  logic              beat_gt_second;

  sm_compare #(
    .DATA_W (DATA_W)
  ) u_cmp_second (
    .a_i      (in_data),
    .b_i      (second_q),
    .a_gt_b_o (beat_gt_second)
  );

  assign out_max2   = out_max2_q;
  assign out_index2 = out_index2_q;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    sat_d       = sat_q;
    out_max_d   = out_max_q;
    out_index_d = out_index_q;
    out_sat_d   = out_sat_q;
`ifdef ARGMAX_TOP2_EN
    second_d     = second_q;
    second_idx_d = second_idx_q;
    out_max2_d   = out_max2_q;
    out_index2_d = out_index2_q;
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          if (first_beat || beat_gt_best) begin
            best_d     = in_data;
            best_idx_d = beat_idx;
          end
`ifdef ARGMAX_TOP2_EN
          if (!first_beat) begin
            if (beat_gt_best) begin
              second_d     = best_q;
              second_idx_d = best_idx_q;
            end else if ((count_q == IDX_W'(1)) || beat_gt_second) begin
              second_d     = in_data;
              second_idx_d = beat_idx;
            end
          end
`endif
          sat_d = (first_beat ? 1'b0 : sat_q) | beat_is_sat;
          if (last_beat) begin
            state_d     = HOLD;
            out_max_d   = best_d;
            out_index_d = best_idx_d;
            out_sat_d   = sat_d;
`ifdef ARGMAX_TOP2_EN
            out_max2_d   = second_d;
            out_index2_d = second_idx_d;
`endif
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          count_d = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      count_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      sat_q       <= 1'b0;
      out_max_q   <= '0;
      out_index_q <= '0;
      out_sat_q   <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      second_q     <= '0;
      second_idx_q <= '0;
      out_max2_q   <= '0;
      out_index2_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      sat_q       <= sat_d;
      out_max_q   <= out_max_d;
      out_index_q <= out_index_d;
      out_sat_q   <= out_sat_d;
`ifdef ARGMAX_TOP2_EN
      second_q     <= second_d;
      second_idx_q <= second_idx_d;
      out_max2_q   <= out_max2_d;
      out_index2_q <= out_index2_d;
`endif
    end
  end

  assign out_max   = out_max_q;
  assign out_index = out_index_q;
  assign out_sat   = out_sat_q;

endmodule
